// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_mux
//  Description : Time-multiplexed scan driver for a 4-digit common-anode
//                7-segment display. Captures a 16-bit value on a load strobe,
//                applies it only at frame boundaries, and walks the digits at
//                a prescaled rate with optional leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_mux #(
    parameter int PRESCALE = 50000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    output logic [3:0]  bin_out,
    output logic        en_out,
    output logic [3:0]  an_out,
    output logic        frame_done
);

    // A one-cycle slot still needs a 1-bit counter to keep the datapath legal.
    localparam int                c_PC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PC_W-1:0] c_PC_MAX = c_PC_W'(PRESCALE - 1);

    logic [c_PC_W-1:0] r_pc;
    logic [1:0]        r_idx;
    logic [15:0]       r_disp;
    logic [15:0]       r_shd;
    logic              r_pending;

    logic              w_tick;
    logic              w_boundary;
    logic [c_PC_W-1:0] w_pc_nxt;
    logic [1:0]        w_idx_nxt;
    logic [15:0]       w_disp_nxt;
    logic [15:0]       w_shd_nxt;
    logic              w_pending_nxt;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [3:0]        w_an;

    assign w_tick     = (r_pc == c_PC_MAX);
    assign w_boundary = w_tick && (r_idx == 2'd3);

    // Next scan position and display/shadow bookkeeping. A load landing on the
    // boundary goes straight to the display and supersedes any shadowed value.
    always_comb begin
        w_pc_nxt      = r_pc + c_PC_W'(1);
        w_idx_nxt     = r_idx;
        w_disp_nxt    = r_disp;
        w_shd_nxt     = r_shd;
        w_pending_nxt = r_pending;
        if (w_tick) begin
            w_pc_nxt  = '0;
            w_idx_nxt = r_idx + 2'd1;
        end
        if (w_boundary) begin
            if (load) begin
                w_disp_nxt    = value;
                w_shd_nxt     = value;
                w_pending_nxt = 1'b0;
            end else if (r_pending) begin
                w_disp_nxt    = r_shd;
                w_pending_nxt = 1'b0;
            end
        end else if (load) begin
            w_shd_nxt     = value;
            w_pending_nxt = 1'b1;
        end
    end

    // Digit outputs derived from the post-edge index and display so the
    // registered nibble, enable and anode always describe the same state.
    always_comb begin
        w_nib   = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
        w_blank = 1'b0;
        unique case (w_idx_nxt)
            2'd1:    w_blank = (w_disp_nxt[15:4]  == 12'h000);
            2'd2:    w_blank = (w_disp_nxt[15:8]  == 8'h00);
            2'd3:    w_blank = (w_disp_nxt[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
        w_blank = w_blank && LZ_BLANK;
        w_an    = w_blank ? 4'b1111 : ~(4'b0001 << w_idx_nxt);
    end

    // State and output registers; reset wins over load and tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_idx      <= 2'd0;
            r_disp     <= 16'h0000;
            r_shd      <= 16'h0000;
            r_pending  <= 1'b0;
            bin_out    <= 4'h0;
            en_out     <= 1'b1;
            an_out     <= 4'b1110;
            frame_done <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_idx      <= w_idx_nxt;
            r_disp     <= w_disp_nxt;
            r_shd      <= w_shd_nxt;
            r_pending  <= w_pending_nxt;
            bin_out    <= w_nib;
            en_out     <= ~w_blank;
            an_out     <= w_an;
            frame_done <= w_boundary;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_mux
//  Description : Self-checking bench for seg7_scan_mux. Three instances
//                (P=4/LZ, P=4/no-LZ, P=1/LZ) share clock and stimulus and are
//                compared against a time-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld  = 1'b0;
    logic [15:0] val = 16'h0000;

    logic [3:0] bin_o [3];
    logic       en_o  [3];
    logic [3:0] an_o  [3];
    logic       fd_o  [3];

    int n_pass  = 0;
    int n_total = 0;

    // Model: edges since reset release, shown value, and deferred value.
    int          c_P  [3] = '{4, 4, 1};
    bit          c_LZ [3] = '{1'b1, 1'b0, 1'b1};
    int          m_n    [3];
    logic [15:0] m_disp [3];
    logic [15:0] m_shd  [3];
    bit          m_pend [3];
    bit          m_fd   [3];

    always #5 clk = ~clk;

    seg7_scan_mux #(.PRESCALE(4), .LZ_BLANK(1'b1)) u_p4_lz (
        .clk(clk), .rst(rst), .load(ld), .value(val),
        .bin_out(bin_o[0]), .en_out(en_o[0]), .an_out(an_o[0]), .frame_done(fd_o[0]));
    seg7_scan_mux #(.PRESCALE(4), .LZ_BLANK(1'b0)) u_p4_nolz (
        .clk(clk), .rst(rst), .load(ld), .value(val),
        .bin_out(bin_o[1]), .en_out(en_o[1]), .an_out(an_o[1]), .frame_done(fd_o[1]));
    seg7_scan_mux #(.PRESCALE(1), .LZ_BLANK(1'b1)) u_p1_lz (
        .clk(clk), .rst(rst), .load(ld), .value(val),
        .bin_out(bin_o[2]), .en_out(en_o[2]), .an_out(an_o[2]), .frame_done(fd_o[2]));

    function automatic int m_dig(int i);
        return (m_n[i] / c_P[i]) % 4;
    endfunction

    // Expected {bin, en, an, frame_done} straight from the display rules.
    function automatic logic [9:0] m_exp(int i);
        int         d;
        logic [3:0] nib;
        logic       en;
        logic [3:0] an;
        d   = m_dig(i);
        nib = 4'((m_disp[i] >> (4 * d)) & 16'h000F);
        en  = !(c_LZ[i] && d > 0 && (m_disp[i] >> (4 * d)) == 16'h0000);
        an  = en ? ~(4'b0001 << d) : 4'b1111;
        return {nib, en, an, m_fd[i]};
    endfunction

    function automatic logic [9:0] obs(int i);
        return {bin_o[i], en_o[i], an_o[i], fd_o[i]};
    endfunction

    // Advance one clock, updating the model with the inputs the DUT sampled.
    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_n[i] = 0; m_disp[i] = 16'h0; m_shd[i] = 16'h0;
                m_pend[i] = 1'b0; m_fd[i] = 1'b0;
            end else begin
                bit b;
                b = (m_n[i] % (4 * c_P[i])) == (4 * c_P[i] - 1);
                if (b) begin
                    if (ld) begin m_disp[i] = val; m_pend[i] = 1'b0; end
                    else if (m_pend[i]) begin m_disp[i] = m_shd[i]; m_pend[i] = 1'b0; end
                end else if (ld) begin
                    m_shd[i] = val; m_pend[i] = 1'b1;
                end
                m_fd[i] = b;
                m_n[i]++;
            end
        end
        #1;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        ld = 1'b1; val = v;
        cycle();
        ld = 1'b0; val = $urandom;
    endtask

    // Step until instance i reports frame_done; ok=0 if the budget expires.
    task automatic wait_frame(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            cycle();
            if (fd_o[i] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (obs(i) !== 10'b0000_1_1110_0)
                    $display("FAIL reset_hold inst%0d: got %b expected %b", i, obs(i), 10'b0000_1_1110_0);
                else n_pass++;
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 24; k++) begin
            logic [3:0] e_an;
            cycle();
            e_an = ((((k + 1) / 4) % 4) == 0) ? 4'b1110 : 4'b1111;
            n_total++;
            if (an_o[0] !== e_an || en_o[0] !== (e_an == 4'b1110))
                $display("FAIL reset_scan k%0d: an=%b en=%b expected an=%b", k, an_o[0], en_o[0], e_an);
            else n_pass++;
        end
    endtask

    task automatic test_scan_deferred();
        bit ok;
        logic [15:0] v;
        v = 16'h1234;
        while ((m_n[0] % 16) != 6) cycle();
        pulse_load(v);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (fd_o[0] === 1'b1) ok = 1'b1;
            else begin
                n_total++;
                if (bin_o[0] !== 4'h0) $display("FAIL deferred_old k%0d: bin=%h expected 0", k, bin_o[0]);
                else n_pass++;
                cycle();
            end
        end
        n_total++;
        if (!ok) $display("FAIL deferred_boundary: frame_done=0 expected a pulse within 40 cycles");
        else n_pass++;
        for (int k = 0; k < 32; k++) begin
            int d;
            logic [9:0] e;
            d = (k / 4) % 4;
            e = {4'(v >> (4 * d)), 1'b1, ~(4'b0001 << d), (k % 16) == 0};
            n_total++;
            if (obs(0) !== e) $display("FAIL scan_order k%0d: got %b expected %b", k, obs(0), e);
            else n_pass++;
            cycle();
        end
    endtask

    task automatic test_lz();
        bit ok;
        pulse_load(16'h0050);
        wait_frame(0, ok);
        n_total++;
        if (!ok) $display("FAIL lz_wait: frame_done=0 expected a pulse");
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            int d;
            logic [9:0] e0, e1;
            d  = k / 4;
            e0 = {(d == 1) ? 4'h5 : 4'h0, d < 2, (d < 2) ? ~(4'b0001 << d) : 4'b1111, k == 0};
            e1 = {(d == 1) ? 4'h5 : 4'h0, 1'b1, ~(4'b0001 << d), k == 0};
            n_total++;
            if (obs(0) !== e0) $display("FAIL lz_0050 k%0d: got %b expected %b", k, obs(0), e0);
            else n_pass++;
            n_total++;
            if (obs(1) !== e1) $display("FAIL nolz_0050 k%0d: got %b expected %b", k, obs(1), e1);
            else n_pass++;
            cycle();
        end
        pulse_load(16'h0000);
        wait_frame(0, ok);
        for (int k = 0; k < 16; k++) begin
            int d;
            logic [9:0] e0;
            d  = k / 4;
            e0 = {4'h0, d == 0, (d == 0) ? 4'b1110 : 4'b1111, k == 0};
            n_total++;
            if (obs(0) !== e0) $display("FAIL lz_0000 k%0d: got %b expected %b", k, obs(0), e0);
            else n_pass++;
            cycle();
        end
    endtask

    task automatic test_multi_and_boundary_load();
        bit ok;
        wait_frame(0, ok);
        cycle();
        pulse_load(16'h1111);
        cycle();
        pulse_load(16'h2222);
        for (int k = 0; k < 36; k++) begin
            n_total++;
            if (bin_o[0] === 4'h1 || obs(0) !== m_exp(0))
                $display("FAIL multi_load k%0d: got %b expected %b", k, obs(0), m_exp(0));
            else n_pass++;
            cycle();
        end
        while ((m_n[0] % 16) != 5) cycle();
        pulse_load(16'h4444);
        while ((m_n[0] % 16) != 15) cycle();
        pulse_load(16'h3333);
        n_total++;
        if (obs(0) !== 10'b0011_1_1110_1)
            $display("FAIL boundary_load: got %b expected %b", obs(0), 10'b0011_1_1110_1);
        else n_pass++;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_total++;
            if (bin_o[0] !== 4'h3) $display("FAIL boundary_keep k%0d: bin=%h expected 3", k, bin_o[0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        pulse_load(16'h9876);
        wait_frame(0, ok);
        for (int k = 0; k < 8; k++) cycle();
        n_total++;
        if (obs(0) !== {4'h8, 1'b1, 4'b1011, 1'b0})
            $display("FAIL pre_reset_digit2: got %b expected %b", obs(0), {4'h8, 1'b1, 4'b1011, 1'b0});
        else n_pass++;
        pulse_load(16'h5555);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_total++;
        if (obs(0) !== 10'b0000_1_1110_0)
            $display("FAIL reset_mid: got %b expected %b", obs(0), 10'b0000_1_1110_0);
        else n_pass++;
        for (int k = 0; k < 40; k++) begin
            cycle();
            n_total++;
            if (bin_o[0] !== 4'h0 || obs(0) !== m_exp(0))
                $display("FAIL reset_lost_pending k%0d: got %b expected %b", k, obs(0), m_exp(0));
            else n_pass++;
        end
    endtask

    task automatic test_prescale1();
        bit ok;
        logic [15:0] v;
        v = 16'hABCD;
        pulse_load(v);
        wait_frame(2, ok);
        n_total++;
        if (!ok) $display("FAIL p1_wait: frame_done=0 expected a pulse");
        else n_pass++;
        for (int k = 0; k < 12; k++) begin
            int d;
            logic [9:0] e;
            d = k % 4;
            e = {4'(v >> (4 * d)), 1'b1, ~(4'b0001 << d), d == 0};
            n_total++;
            if (obs(2) !== e) $display("FAIL p1_scan k%0d: got %b expected %b", k, obs(2), e);
            else n_pass++;
            cycle();
        end
    endtask

    task automatic test_random();
        logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        for (int k = 0; k < 400; k++) begin
            ld  = ($urandom_range(0, 7) == 0);
            val = 16'($urandom) & masks[$urandom_range(0, 4)];
            cycle();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (obs(i) !== m_exp(i))
                    $display("FAIL random inst%0d k%0d: got %b expected %b", i, k, obs(i), m_exp(i));
                else n_pass++;
            end
        end
        ld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_deferred();
        test_lz();
        test_multi_and_boundary_load();
        test_reset_mid();
        test_prescale1();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed scan driver for a 4-digit common-anode 7-segment display. Captures a 16-bit value (four 4-bit digit codes) on a load strobe and cycles through the digits at a prescaled rate. Each step presents one nibble plus a blank enable to the downstream 7-segment decoder (nibble → `bin_in`, enable → `en`) and drives the matching active-low anode. A new value takes effect only at a frame boundary, so the display never shows a mix of old and new digits.

## Interface
- `PRESCALE`, 50000 — clock cycles per digit slot; legal range ≥ 1.
- `LZ_BLANK`, 1 — when 1, leading-zero digits are blanked; when 0, all digits are always shown.

- `clk`  in  1  — system clock; all state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `load`  in  1  — one-cycle strobe; capture `value`.
- `value`  in  16  — `[3:0]` is digit 0 (least significant, rightmost); `[15:12]` is digit 3.
- `bin_out`  out  4  — nibble of the current digit; connects to the decoder's `bin_in`.
- `en_out`  out  1  — decoder enable; 0 blanks the segments.
- `an_out`  out  4  — active-low anode selects; bit k drives digit k.
- `frame_done`  out  1  — one-cycle pulse when digit 3's slot ends.

## Operation
- Internal state:
  - prescale counter `pc` (0..PRESCALE-1)
  - digit index `idx` (2 bits)
  - display register `disp` (16 bits)
  - shadow register `shd` (16 bits)
  - `pending` flag
- `tick` = (`pc` == PRESCALE-1).
  - On `tick`: `pc` ← 0 and `idx` ← `idx`+1, wrapping 3 → 0.
  - Otherwise: `pc` ← `pc`+1.
  - With PRESCALE = 1, `tick` is asserted every cycle.
- Frame boundary = `tick` while `idx` == 3.
- Load handling:
  - `load` outside a boundary cycle: `shd` ← `value`, `pending` ← 1. Repeated loads within one frame overwrite `shd`; the last one wins.
  - At a boundary with `pending` = 1: `disp` ← `shd`, `pending` ← 0.
  - `load` coinciding with a boundary: `disp` ← `value` directly and `pending` ← 0. The new value also supersedes any older value held in `shd`.
- Leading-zero blanking (`LZ_BLANK` = 1):
  - Digit k ∈ {1,2,3} is blank iff nibbles k..3 of `disp` are all zero.
  - Digit 0 is never blanked.
- Output per digit slot, computed from the post-edge `idx` and `disp`:
  - Normal digit: `an_out` has only bit `idx` low; `bin_out` = `disp[4*idx +: 4]`; `en_out` = 1.
  - Blanked digit: `an_out` = 4'b1111; `en_out` = 0; `bin_out` still carries the nibble (0).
- `bin_out`, `en_out` and `an_out` are registered. They update on the same edge as `idx` and `disp`, so they always reflect one consistent state.
- `frame_done` is registered and high for exactly one cycle: the cycle after each frame boundary edge, i.e. the first cycle of digit 0's slot.

## Timing
- Reset values:

  | Signal | Value |
  |---|---|
  | `pc`, `idx` | 0 |
  | `disp`, `shd` | 16'h0000 |
  | `pending` | 0 |
  | `an_out` | 4'b1110 |
  | `bin_out` | 4'h0 |
  | `en_out` | 1 |
  | `frame_done` | 0 |

- Reset has priority over `load` and `tick`.
- Reset asserted mid-frame discards `disp`, `shd` and `pending`. Scanning restarts at digit 0 with a full PRESCALE slot on the first cycle after `rst` is deasserted.
- Slot length is exactly PRESCALE cycles; a frame is 4·PRESCALE cycles.
- Load-to-display latency:
  - Minimum: 1 cycle (load on a boundary cycle).
  - Maximum: 4·PRESCALE cycles (load in the cycle just after a boundary).
- `load` during reset is ignored.
- `value` is sampled only in cycles where `load` = 1.

## Test plan
1. **Reset:** PRESCALE = 4; hold `rst` for 3 cycles, then release. Expect `an_out` = 1110, `bin_out` = 0, `en_out` = 1, `frame_done` = 0 during reset. After release, `idx` advances every 4 cycles. Digits 1–3 are blanked (`an_out` = 1111, `en_out` = 0).
2. **Scan order and deferred load:** PRESCALE = 4, `LZ_BLANK` = 1; `load` `value` = 16'h1234 in mid-frame. Until the next boundary, the old value (0) is still shown. From the boundary on, the sequence is:
   - `bin_out` 4 / `an_out` 1110
   - `bin_out` 3 / `an_out` 1101
   - `bin_out` 2 / `an_out` 1011
   - `bin_out` 1 / `an_out` 0111

   Each step lasts 4 cycles and the pattern repeats. `frame_done` pulses every 16 cycles, in the first cycle of digit 0's slot.
3. **Leading-zero blanking:**
   - `value` = 16'h0050: digits 0 and 1 show 0 and 5; digits 2 and 3 have `en_out` = 0, `an_out` = 1111.
   - `value` = 16'h0000: only digit 0 shows 0.
   - `value` = 16'h0050 with `LZ_BLANK` = 0: all four digits shown, `en_out` = 1 throughout.
4. **Multiple and boundary loads:**
   - `load` 16'h1111 then 16'h2222 within one frame: only 2222 is ever displayed.
   - `load` 16'h3333 in the exact boundary cycle: digit 0 shows 3 in the very next cycle, and the subsequent boundary leaves `disp` unchanged.
5. **Reset mid-operation:** with 16'h9876 displayed, assert `rst` during digit 2's slot. The next cycle shows reset values (`disp` = 0, `an_out` = 1110), and the pending value is lost.
6. **PRESCALE = 1:** `load` 16'hABCD. Once the boundary passes, the digit changes every cycle (D, C, B, A), and `frame_done` pulses every 4 cycles.
